grover_measure: RTL and testbench



---
 rtl/grover_measure.sv | 206 ++++++++++++++++++++
 tb/tb_grover_measure.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grover_measure.sv
// Measurement back end for the 3-qubit Grover engine: collapses eight signed
// amplitudes to one basis index by argmax of a^2 or by an LFSR-weighted sample.
module grover_measure #(
    parameter int          num_bit        = 3,
    parameter int          fixedpoint_bit = 8,
    parameter int          num_sample     = 8,
    parameter logic [15:0] lfsr_seed      = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          mode,
    input  logic [fixedpoint_bit-1:0]     i0,
    input  logic [fixedpoint_bit-1:0]     i1,
    input  logic [fixedpoint_bit-1:0]     i2,
    input  logic [fixedpoint_bit-1:0]     i3,
    input  logic [fixedpoint_bit-1:0]     i4,
    input  logic [fixedpoint_bit-1:0]     i5,
    input  logic [fixedpoint_bit-1:0]     i6,
    input  logic [fixedpoint_bit-1:0]     i7,
    output logic [num_bit-1:0]            result_index,
    output logic [2*fixedpoint_bit-1:0]   result_prob,
    output logic                          zero_flag,
    output logic                          valid,
    output logic                          busy
);

    localparam int SQ_W   = 2 * fixedpoint_bit;
    // Eight squares of at most 2^(2F-2) each need 2F-1+num_bit bits in total.
    localparam int TOT_W  = 2 * fixedpoint_bit - 1 + num_bit;
    localparam int PROD_W = 16 + TOT_W;
    localparam logic [num_bit-1:0] K_LAST = num_bit'(num_sample - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUM,
        S_PICK,
        S_SCAN,
        S_DONE
    } state_t;

    state_t                            state_reg;
    logic                              mode_reg;
    logic signed [fixedpoint_bit-1:0]  amp_reg [num_sample];
    logic [num_bit-1:0]                k_reg;
    logic [TOT_W-1:0]                  total_reg;
    logic [TOT_W-1:0]                  cum_reg;
    logic [TOT_W-1:0]                  thr_reg;
    logic [SQ_W-1:0]                   best_reg;
    logic [num_bit-1:0]                best_idx_reg;
    logic [num_bit-1:0]                pend_idx_reg;
    logic [SQ_W-1:0]                   pend_prob_reg;
    logic                              pend_zero_reg;
    logic [15:0]                       lfsr_reg;

    logic [fixedpoint_bit-1:0]         in_amp [num_sample];
    logic [SQ_W-1:0]                   sq_all [num_sample];
    logic [SQ_W-1:0]                   sq_k;
    logic [TOT_W-1:0]                  total_next;
    logic [TOT_W-1:0]                  cum_next;
    logic [PROD_W-1:0]                 thr_prod;
    logic [TOT_W-1:0]                  thr_next;
    logic                              sq_is_best;

    assign in_amp[0] = i0;
    assign in_amp[1] = i1;
    assign in_amp[2] = i2;
    assign in_amp[3] = i3;
    assign in_amp[4] = i4;
    assign in_amp[5] = i5;
    assign in_amp[6] = i6;
    assign in_amp[7] = i7;

    // Sign-extend before squaring so -128 * -128 yields +16384.
    generate
        for (genvar gi = 0; gi < num_sample; gi++) begin : g_sq
            logic signed [SQ_W-1:0] amp_ext;
            logic signed [SQ_W-1:0] prod;
            assign amp_ext    = SQ_W'(amp_reg[gi]);
            assign prod       = amp_ext * amp_ext;
            assign sq_all[gi] = $unsigned(prod);
        end
    endgenerate

    assign sq_k       = sq_all[k_reg];
    assign total_next = total_reg + TOT_W'(sq_k);
    assign cum_next   = cum_reg + TOT_W'(sq_k);
    assign sq_is_best = (sq_k > best_reg);

    // Scaling a 16-bit uniform value by total keeps thr strictly below total.
    assign thr_prod   = PROD_W'(lfsr_reg) * PROD_W'(total_reg);
    assign thr_next   = TOT_W'(thr_prod >> 16);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= lfsr_seed;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0],
                         lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            mode_reg      <= 1'b0;
            for (int j = 0; j < num_sample; j++) begin
                amp_reg[j] <= '0;
            end
            k_reg         <= '0;
            total_reg     <= '0;
            cum_reg       <= '0;
            thr_reg       <= '0;
            best_reg      <= '0;
            best_idx_reg  <= '0;
            pend_idx_reg  <= '0;
            pend_prob_reg <= '0;
            pend_zero_reg <= 1'b0;
            result_index  <= '0;
            result_prob   <= '0;
            zero_flag     <= 1'b0;
            valid         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // A start coinciding with the result strobe is dropped.
                    if (start && !valid) begin
                        for (int j = 0; j < num_sample; j++) begin
                            amp_reg[j] <= $signed(in_amp[j]);
                        end
                        mode_reg     <= mode;
                        total_reg    <= '0;
                        best_reg     <= '0;
                        best_idx_reg <= '0;
                        k_reg        <= '0;
                        busy         <= 1'b1;
                        state_reg    <= S_SUM;
                    end
                end

                S_SUM: begin
                    total_reg <= total_next;
                    if (sq_is_best) begin
                        best_reg     <= sq_k;
                        best_idx_reg <= k_reg;
                    end
                    if (k_reg == K_LAST) begin
                        state_reg <= mode_reg ? S_PICK : S_DONE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end

                S_PICK: begin
                    if (total_reg == '0) begin
                        pend_idx_reg  <= '0;
                        pend_prob_reg <= '0;
                        pend_zero_reg <= 1'b1;
                        state_reg     <= S_DONE;
                    end else begin
                        thr_reg   <= thr_next;
                        cum_reg   <= '0;
                        k_reg     <= '0;
                        state_reg <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    cum_reg <= cum_next;
                    // The last index is a guaranteed hit; the guard only keeps k bounded.
                    if ((cum_next > thr_reg) || (k_reg == K_LAST)) begin
                        pend_idx_reg  <= k_reg;
                        pend_prob_reg <= sq_k;
                        pend_zero_reg <= 1'b0;
                        state_reg     <= S_DONE;
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end

                S_DONE: begin
                    if (mode_reg) begin
                        result_index <= pend_idx_reg;
                        result_prob  <= pend_prob_reg;
                        zero_flag    <= pend_zero_reg;
                    end else begin
                        result_index <= best_idx_reg;
                        result_prob  <= best_reg;
                        zero_flag    <= (total_reg == '0);
                    end
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grover_measure.sv
// Scoreboard bench for grover_measure: a behavioural model predicts index,
// probability, zero flag and arrival cycle for every accepted request.
module tb_grover_measure;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [7:0]  amp_drv [8];
    logic [2:0]  result_index;
    logic [15:0] result_prob;
    logic        zero_flag;
    logic        valid;
    logic        busy;

    grover_measure dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .i0           (amp_drv[0]),
        .i1           (amp_drv[1]),
        .i2           (amp_drv[2]),
        .i3           (amp_drv[3]),
        .i4           (amp_drv[4]),
        .i5           (amp_drv[5]),
        .i6           (amp_drv[6]),
        .i7           (amp_drv[7]),
        .result_index (result_index),
        .result_prob  (result_prob),
        .zero_flag    (zero_flag),
        .valid        (valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int prob;
        int zero;
        int due;
    } exp_t;

    exp_t        sb [$];
    int          checks     = 0;
    int          failures   = 0;
    int          cyc        = 0;
    int          valid_seen = 0;
    logic [7:0]  amp_q [8];
    logic [15:0] tb_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_lfsr <= 16'hACE1;
        else     tb_lfsr <= lfsr_step(tb_lfsr);
    end

    // Pop and compare whenever the DUT strobes a result.
    always @(negedge clk) begin
        if (valid) begin
            exp_t e;
            valid_seen++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid cycle=%0d index=%0d", cyc, result_index);
            end else begin
                e = sb.pop_front();
                $display("txn cycle=%0d index=%0d prob=%0d zero=%0d", cyc, result_index, result_prob, zero_flag);
                if (result_index !== 3'(e.idx)) begin
                    failures++;
                    $display("FAIL result_index got=%0d want=%0d", result_index, e.idx);
                end
                checks++;
                if (result_prob !== 16'(e.prob)) begin
                    failures++;
                    $display("FAIL result_prob got=%0d want=%0d", result_prob, e.prob);
                end
                checks++;
                if (zero_flag !== 1'(e.zero)) begin
                    failures++;
                    $display("FAIL zero_flag got=%0d want=%0d", zero_flag, e.zero);
                end
                checks++;
                if (cyc !== e.due) begin
                    failures++;
                    $display("FAIL latency got_cycle=%0d want_cycle=%0d", cyc, e.due);
                end
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_at_valid got=%0d want=0", busy);
                end
            end
        end
    end

    task automatic issue(input logic m);
        exp_t        e;
        logic [15:0] l;
        int          sq [8];
        int          total, best, bi, lat, a;
        longint      thr, cum;
        bit          hit;
        @(negedge clk);
        for (int i = 0; i < 8; i++) amp_drv[i] = amp_q[i];
        mode  = m;
        start = 1'b1;
        l = tb_lfsr;
        repeat (9) l = lfsr_step(l);
        total = 0; best = 0; bi = 0;
        for (int i = 0; i < 8; i++) begin
            a     = int'($signed(amp_q[i]));
            sq[i] = a * a;
            total += sq[i];
            if (sq[i] > best) begin
                best = sq[i];
                bi   = i;
            end
        end
        if (!m) begin
            e.idx = bi; e.prob = best; e.zero = (total == 0); lat = 9;
        end else if (total == 0) begin
            e.idx = 0; e.prob = 0; e.zero = 1; lat = 10;
        end else begin
            thr = (longint'(l) * longint'(total)) >> 16;
            cum = 0; hit = 0; e.idx = 7; e.prob = sq[7]; e.zero = 0; lat = 18;
            for (int i = 0; i < 8; i++) begin
                cum += sq[i];
                if (!hit && cum > thr) begin
                    hit = 1; e.idx = i; e.prob = sq[i]; lat = 11 + i;
                end
            end
        end
        e.due = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL result_timeout pending=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 8; i++) amp_q[i] = 8'(v);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        for (int i = 0; i < 8; i++) amp_drv[i] = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({result_index, result_prob, zero_flag, valid, busy} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {result_index, result_prob, zero_flag, valid, busy});
        end
    endtask

    task automatic test_uniform();
        int bc = 0;
        int n  = 0;
        set_all(23);
        issue(1'b0);
        while (!valid && n < 40) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (bc !== 9) begin
            failures++;
            $display("FAIL busy_cycles got=%0d want=9", bc);
        end
        wait_idle();
        checks++;
        if (result_prob !== 16'd529 || result_index !== 3'd0) begin
            failures++;
            $display("FAIL uniform got=%0d/%0d want=0/529", result_index, result_prob);
        end
    endtask

    task automatic test_argmax();
        set_all(10); amp_q[5] = 8'(-90);
        issue(1'b0);
        wait_idle();
        checks++;
        if (result_index !== 3'd5 || result_prob !== 16'd8100) begin
            failures++;
            $display("FAIL argmax_i5 got=%0d/%0d want=5/8100", result_index, result_prob);
        end
        amp_q[2] = 8'(-128);
        issue(1'b0);
        wait_idle();
        checks++;
        if (result_index !== 3'd2 || result_prob !== 16'd16384) begin
            failures++;
            $display("FAIL argmax_i2 got=%0d/%0d want=2/16384", result_index, result_prob);
        end
    endtask

    task automatic test_single_peak();
        set_all(0); amp_q[3] = 8'd64;
        for (int r = 0; r < 20; r++) begin
            issue(1'b1);
            wait_idle();
            checks++;
            if (result_index !== 3'd3 || result_prob !== 16'd4096) begin
                failures++;
                $display("FAIL peak_rep%0d got=%0d/%0d want=3/4096", r, result_index, result_prob);
            end
            repeat ($urandom_range(0, 7)) @(negedge clk);
        end
    endtask

    task automatic test_zero();
        set_all(0);
        issue(1'b1);
        wait_idle();
        checks++;
        if (zero_flag !== 1'b1) begin
            failures++;
            $display("FAIL zero_mode1 got=%0d want=1", zero_flag);
        end
        issue(1'b0);
        wait_idle();
        checks++;
        if (zero_flag !== 1'b1 || result_prob !== 16'd0) begin
            failures++;
            $display("FAIL zero_mode0 got=%0d/%0d want=1/0", zero_flag, result_prob);
        end
    endtask

    task automatic test_pair();
        int cnt0 = 0;
        int cnt1 = 0;
        set_all(0); amp_q[0] = 8'd90; amp_q[1] = 8'd90;
        for (int r = 0; r < 200; r++) begin
            issue(1'b1);
            wait_idle();
            if (result_index == 3'd0) cnt0++;
            if (result_index == 3'd1) cnt1++;
            checks++;
            if (result_prob !== 16'd8100) begin
                failures++;
                $display("FAIL pair_prob_rep%0d got=%0d want=8100", r, result_prob);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        checks++;
        if (cnt0 + cnt1 !== 200 || cnt0 == 0 || cnt1 == 0) begin
            failures++;
            $display("FAIL pair_spread got=%0d,%0d want=both>0 sum=200", cnt0, cnt1);
        end
    endtask

    task automatic test_start_ignored();
        int vs0 = valid_seen;
        set_all(5); amp_q[6] = 8'(-40);
        issue(1'b0);
        repeat (2) @(negedge clk);
        set_all(100);
        for (int i = 0; i < 8; i++) amp_drv[i] = amp_q[i];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (15) @(negedge clk);
        checks++;
        if (valid_seen - vs0 !== 1) begin
            failures++;
            $display("FAIL restart_in_sum valids=%0d want=1", valid_seen - vs0);
        end
    endtask

    task automatic test_start_on_valid();
        int vs0 = valid_seen;
        int n   = 0;
        set_all(7);
        issue(1'b0);
        while (!valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_on_valid busy=%0d want=0", busy);
        end
        repeat (15) @(negedge clk);
        wait_idle();
        checks++;
        if (valid_seen - vs0 !== 1) begin
            failures++;
            $display("FAIL start_on_valid valids=%0d want=1", valid_seen - vs0);
        end
    endtask

    task automatic test_reset_abort();
        int vs0;
        set_all(0); amp_q[4] = 8'd50;
        issue(1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({result_index, result_prob, zero_flag, valid, busy} !== 22'd0) begin
            failures++;
            $display("FAIL abort_outputs got=%h want=0", {result_index, result_prob, zero_flag, valid, busy});
        end
        rst = 1'b0;
        sb.delete();
        vs0 = valid_seen;
        repeat (20) @(negedge clk);
        checks++;
        if (valid_seen !== vs0) begin
            failures++;
            $display("FAIL abort_valid valids=%0d want=0", valid_seen - vs0);
        end
        issue(1'b0);
        wait_idle();
        checks++;
        if (result_index !== 3'd4 || result_prob !== 16'd2500) begin
            failures++;
            $display("FAIL after_abort got=%0d/%0d want=4/2500", result_index, result_prob);
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_argmax();
        test_single_peak();
        test_zero();
        test_pair();
        test_start_ignored();
        test_start_on_valid();
        test_reset_abort();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
